// File: rtl/counter_uart_pkg.sv
// Shared types and constants for the counter UART transmitter.
// 8N1 framing: one start bit, eight data bits, one stop bit.
package counter_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/counter_uart_tx_baud.sv
// Bit-period timer: tick is high in the last cycle of each bit period.
// restart holds the count at zero so a frame always begins on a fresh period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_uart_tx.sv
// UART transmitter for a counter value: explicit start or auto-send on change.
// All outputs are registered; tx is driven from the next-state values.
module counter_uart_tx
  import counter_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       start,
  input  logic       auto_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] last_q, last_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
  logic       req;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state_q == ST_IDLE),
    .tick   (tick)
  );

  assign req = start || (auto_en && (data_in != last_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_START;
          bit_d   = '0;
          shift_d = data_in;
          last_d  = data_in;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // shift_d[0] is the bit that will be on the line after this edge
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    unique case (1'b1)
      (state_d == ST_START): tx_d = 1'b0;
      (state_d == ST_DATA):  tx_d = shift_d[0];
      default:               tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_counter_uart_tx.sv
// Randomised and directed bench for counter_uart_tx.
// A frame-position reference model predicts tx/busy/done every cycle.
module tb_counter_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = counter_uart_pkg::FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       tx;
  logic       busy;
  logic       done;

  counter_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .start  (start),
    .auto_en(auto_en),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int dut_frames = 0;

  bit       m_active = 0;
  int       m_pos = 0;
  bit       m_done = 0;
  bit [7:0] m_byte = 8'h00;
  bit [7:0] m_last = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_step(input bit s, input bit a,
                            input bit [7:0] d);
    if (!m_active) begin
      m_done = 0;
      if (s || (a && (d != m_last))) begin
        m_active = 1;
        m_pos = 0;
        m_byte = d;
        m_last = d;
      end
    end else begin
      m_pos++;
      if (m_pos == FRAME_CYC) begin
        m_active = 0;
        m_done = 1;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit s, input bit a, input bit [7:0] d);
    start = s;
    auto_en = a;
    data_in = d;
    @(posedge clk);
    model_step(s, a, d);
    #1;
    if (done === 1'b1) dut_frames++;
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("done", {31'd0, done}, {31'd0, m_done});
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    auto_en = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    m_active = 0;
    m_pos = 0;
    m_done = 0;
    m_last = 8'h00;
    m_byte = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit [9:0] pat;
    bit [7:0] d;
    bit a;

    @(negedge clk);
    do_reset();

    // single start of 0xA5: explicit waveform
    pat = 10'b1_1010_0101_0;
    cycle(1, 0, 8'hA5);
    check("a5_bit0", {31'd0, tx}, 32'd0);
    base = dut_frames;
    for (int i = 1; i < 46; i++) begin
      cycle(0, 0, 8'hA5);
      if (i < FRAME_CYC)
        check("a5_tx", {31'd0, tx}, {31'd0, pat[i/CPB]});
      check("a5_busy", {31'd0, busy}, {31'd0, (i < FRAME_CYC)});
      check("a5_done", {31'd0, done}, {31'd0, (i == FRAME_CYC)});
    end
    check("a5_frames", dut_frames - base, 32'd1);

    // auto send on 0x00 -> 0x01
    do_reset();
    base = dut_frames;
    repeat (5) cycle(0, 1, 8'h00);
    check("auto_none", dut_frames - base, 32'd0);
    repeat (120) cycle(0, 1, 8'h01);
    check("auto_one", dut_frames - base, 32'd1);

    // sustained start: back-to-back frames
    base = dut_frames;
    repeat (3 * (FRAME_CYC + 1)) cycle(1, 0, 8'h3C);
    check("held_frames", dut_frames - base, 32'd3);
    repeat (45) cycle(0, 0, 8'h3C);

    // mid-frame change under auto
    base = dut_frames;
    cycle(0, 1, 8'h10);
    repeat (15) cycle(0, 1, 8'h10);
    repeat (100) cycle(0, 1, 8'hFF);
    check("chg_frames", dut_frames - base, 32'd2);

    // reset during data bit 3 aborts the frame
    base = dut_frames;
    cycle(1, 0, 8'h55);
    repeat (17) cycle(0, 0, 8'h55);
    do_reset();
    repeat (60) cycle(0, 1, 8'h00);
    check("abort_frames", dut_frames - base, 32'd0);

    // start and auto request together
    base = dut_frames;
    cycle(1, 1, 8'h77);
    repeat (60) cycle(0, 1, 8'h77);
    check("both_frames", dut_frames - base, 32'd1);

    // random traffic
    d = 8'h77;
    a = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) d = 8'($urandom);
      if ($urandom_range(0, 99) == 0) a = ~a;
      if ($urandom_range(0, 899) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 39) == 0, a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
